cdb_mem_responder: RTL and testbench
====================================

Name: cdb_mem_responder

Overview:
- Memory-side responder for the CPU common-data-bus protocol (op / io_address / common_data_bus / rd_valid / tx_done).
- Services the CPU's line-sized READ and WRITE commands against a 512-bit host line interface.
- Stages each line in a 16x32 buffer between the two sides.
- Sits between the CPU loopback engine and the host memory port.

Parameters:
- ADDR_W, 64, io_address and host address width
- WORD_W, 32, common data bus width
- LINE_WORDS, 16, words per line; the host line width is WORD_W*LINE_WORDS = 512

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- op  in  2  CPU command: 00 NOP, 01 READ, 11 WRITE, 10 reserved (treated as NOP)
- io_address  in  ADDR_W  CPU line address
- cdb_from_cpu  in  WORD_W  CPU write data (the CPU's common_data_bus_out)
- cdb_to_cpu  out  WORD_W  read data to the CPU (the CPU's common_data_bus_in)
- rd_valid  out  1  cdb_to_cpu holds a valid read word this cycle
- tx_done  out  1  single-cycle pulse: command complete
- host_rd_req  out  1  single-cycle host line read request
- host_rd_addr  out  ADDR_W  host read address, line aligned
- host_rd_valid  in  1  host read data valid, one cycle
- host_rd_data  in  512  host read line
- host_wr_req  out  1  single-cycle host line write request
- host_wr_addr  out  ADDR_W  host write address, line aligned
- host_wr_data  out  512  host write line
- host_wr_ack  in  1  host write complete, one cycle

Behaviour:
- Reset is asynchronous on posedge rst. It forces:
  - state IDLE
  - all outputs 0
  - word counter 0
  - line buffer 0
- Reset mid-transaction aborts immediately. Any host response arriving later is ignored.
- State machine:
  - IDLE:
    - op==01 -> RD_REQ, latching io_address.
    - op==11 -> WR_CAP, latching io_address, counter=0.
    - 00/10 -> stay.
    - op is sampled only in IDLE; changes in op during other states are ignored.
  - RD_REQ:
    - host_rd_req=1 for exactly one cycle.
    - host_rd_addr = latched address with bits [5:0] cleared.
    - -> RD_WAIT.
  - RD_WAIT:
    - On host_rd_valid, buffer[i] <= host_rd_data[32*i+31:32*i] for i=0..15, counter=0, -> RD_STRM.
    - No timeout.
  - RD_STRM:
    - Each cycle: rd_valid=1, cdb_to_cpu=buffer[counter], counter++.
    - On counter==15: tx_done=1 in the same cycle as the last rd_valid, -> IDLE.
    - Read latency from the host_rd_valid cycle to the first rd_valid is 1 cycle.
  - WR_CAP:
    - Each cycle: buffer[counter] <= cdb_from_cpu, counter++.
    - The first capture is in the cycle after op==11 was sampled in IDLE, so the CPU's setup cycle is skipped.
    - After counter==15 is captured -> WR_REQ.
  - WR_REQ:
    - host_wr_req=1 for one cycle, with host_wr_addr line aligned.
    - host_wr_data = concatenation of buffer, word 0 in bits [31:0].
    - -> WR_WAIT.
  - WR_WAIT:
    - On host_wr_ack: tx_done=1 for one cycle, -> IDLE.
- Outputs and counter:
  - rd_valid and tx_done are registered-state decodes. They are never high in IDLE, RD_REQ, RD_WAIT, WR_CAP or WR_REQ.
  - cdb_to_cpu is 0 whenever rd_valid=0.
  - The counter is 4 bits and wraps 15->0 naturally; no overflow flag.
- Simultaneous/stray events:
  - host_rd_valid outside RD_WAIT and host_wr_ack outside WR_WAIT are ignored.
  - A host response in the same cycle as the request is legal only from the next state; a responding host must give at least 1 cycle of latency.
- Back-to-back commands: after tx_done, IDLE samples op on the next cycle, so there is a minimum 1-cycle gap between commands.

Decomposition:
- Package cdb_pkg holds:
  - the op encoding enum (NOP/READ/RSVD/WRITE)
  - the responder state enum
  - LINE_WORDS
  - the line-offset mask constant (6 bits)
- The CPU module imports cdb_pkg for the op encoding.
- One sub-module, cdb_line_buffer: 16x32 storage with
  - a per-word write port
  - a parallel 512-bit load
  - a parallel 512-bit read
  - a word read by index
- All control stays in cdb_mem_responder.

Test Plan:
- Read path: op=01, io_address=0x1047, host returns host_rd_valid with word i = 0xA0000000+i, 5 cycles after the request.
  - host_rd_addr=0x1040.
  - rd_valid high 16 consecutive cycles with data 0xA0000000..0xA000000F.
  - tx_done coincides with 0xA000000F.
- Write path: op=11, io_address=0x400, CPU drives a setup cycle then 0xB0..0xBF.
  - host_wr_addr=0x400.
  - host_wr_data[31:0]=0xB0, [511:480]=0xBF.
  - tx_done exactly one cycle after host_wr_ack.
- Loopback: read then write as the CPU sequences them.
  - Data written to host equals data read; no rd_valid during the write.
- Op ignore: op=10 or 00 held for 20 cycles gives no host requests. op toggling 01->11 during RD_WAIT does not alter the read.
- Reset mid-stream: assert rst at the 8th rd_valid.
  - All outputs 0 the same cycle.
  - A later host_wr_ack or host_rd_valid is ignored.
  - Next op=01 performs a clean full read.
- Stray responses: host_wr_ack pulsed in IDLE and host_rd_valid pulsed in WR_CAP give no state change and no tx_done.

Source files
------------

// File: rtl/cdb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cdb_pkg
// Brief    : Shared encodings and constants for the common-data-bus memory
//            responder.
// Revision : 1.0 - initial release
// ============================================================================
package cdb_pkg;

    typedef enum logic [1:0] {
        OP_NOP   = 2'b00,
        OP_READ  = 2'b01,
        OP_RSVD  = 2'b10,
        OP_WRITE = 2'b11
    } cdb_op_e;

    // ST_WR_DONE holds the one-cycle write tx_done, so tx_done never shows in IDLE.
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_RD_REQ  = 3'd1,
        ST_RD_WAIT = 3'd2,
        ST_RD_STRM = 3'd3,
        ST_WR_CAP  = 3'd4,
        ST_WR_REQ  = 3'd5,
        ST_WR_WAIT = 3'd6,
        ST_WR_DONE = 3'd7
    } rsp_state_e;

    localparam int LINE_WORDS      = 16;
    localparam int C_LINE_OFF_BITS = 6;
    localparam logic [C_LINE_OFF_BITS-1:0] C_LINE_OFF_MASK = '1;

endpackage
`default_nettype wire

// File: rtl/cdb_line_buffer.sv
`default_nettype none
// ============================================================================
// Module   : cdb_line_buffer
// Brief    : LINE_WORDS x WORD_W line staging store with per-word write,
//            full-line load, full-line read and indexed word read.
// Revision : 1.0 - initial release
// ============================================================================
module cdb_line_buffer #(
    parameter int WORD_W     = 32,
    parameter int LINE_WORDS = 16,
    parameter int IDX_W      = $clog2(LINE_WORDS)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         i_wr_en,
    input  logic [IDX_W-1:0]             i_wr_idx,
    input  logic [WORD_W-1:0]            i_wr_data,
    input  logic                         i_load_en,
    input  logic [WORD_W*LINE_WORDS-1:0] i_load_data,
    input  logic [IDX_W-1:0]             i_rd_idx,
    output logic [WORD_W*LINE_WORDS-1:0] o_line,
    output logic [WORD_W-1:0]            o_rd_word
);
    import cdb_pkg::*;

    // Word 0 sits in the least-significant slice of the flattened line.
    logic [LINE_WORDS-1:0][WORD_W-1:0] r_mem;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mem <= '0;
        end else if (i_load_en) begin
            r_mem <= i_load_data;
        end else if (i_wr_en) begin
            r_mem[i_wr_idx] <= i_wr_data;
        end
    end

    assign o_line    = r_mem;
    assign o_rd_word = r_mem[i_rd_idx];

endmodule
`default_nettype wire

// File: rtl/cdb_mem_responder.sv
`default_nettype none
// ============================================================================
// Module   : cdb_mem_responder
// Brief    : Memory-side responder servicing CPU line READ/WRITE commands
//            against a 512-bit host line interface.
// Revision : 1.0 - initial release
// ============================================================================
module cdb_mem_responder #(
    parameter int ADDR_W     = 64,
    parameter int WORD_W     = 32,
    parameter int LINE_WORDS = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [1:0]                   op,
    input  logic [ADDR_W-1:0]            io_address,
    input  logic [WORD_W-1:0]            cdb_from_cpu,
    output logic [WORD_W-1:0]            cdb_to_cpu,
    output logic                         rd_valid,
    output logic                         tx_done,
    output logic                         host_rd_req,
    output logic [ADDR_W-1:0]            host_rd_addr,
    input  logic                         host_rd_valid,
    input  logic [WORD_W*LINE_WORDS-1:0] host_rd_data,
    output logic                         host_wr_req,
    output logic [ADDR_W-1:0]            host_wr_addr,
    output logic [WORD_W*LINE_WORDS-1:0] host_wr_data,
    input  logic                         host_wr_ack
);
    import cdb_pkg::*;

    localparam int                  CNT_W        = $clog2(LINE_WORDS);
    localparam logic [CNT_W-1:0]    C_LAST_IDX   = CNT_W'(LINE_WORDS - 1);
    localparam logic [ADDR_W-1:0]   C_ALIGN_MASK = ~ADDR_W'(C_LINE_OFF_MASK);

    rsp_state_e          r_state;
    logic [CNT_W-1:0]    r_cnt;
    logic [ADDR_W-1:0]   r_addr;

    logic                w_last;
    logic                w_buf_wr_en;
    logic                w_buf_load;
    logic [WORD_W-1:0]   w_rd_word;

    assign w_last      = (r_cnt == C_LAST_IDX);
    assign w_buf_wr_en = (r_state == ST_WR_CAP);
    assign w_buf_load  = (r_state == ST_RD_WAIT) && host_rd_valid;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_addr  <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (op == OP_READ) begin
                        r_addr  <= io_address;
                        r_state <= ST_RD_REQ;
                    end else if (op == OP_WRITE) begin
                        r_addr  <= io_address;
                        r_cnt   <= '0;
                        r_state <= ST_WR_CAP;
                    end
                end
                ST_RD_REQ:  r_state <= ST_RD_WAIT;
                ST_RD_WAIT: begin
                    if (host_rd_valid) begin
                        r_cnt   <= '0;
                        r_state <= ST_RD_STRM;
                    end
                end
                ST_RD_STRM: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (w_last) r_state <= ST_IDLE;
                end
                ST_WR_CAP: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (w_last) r_state <= ST_WR_REQ;
                end
                ST_WR_REQ:  r_state <= ST_WR_WAIT;
                ST_WR_WAIT: begin
                    if (host_wr_ack) r_state <= ST_WR_DONE;
                end
                ST_WR_DONE: r_state <= ST_IDLE;
                default:    r_state <= ST_IDLE;
            endcase
        end
    end

    cdb_line_buffer #(
        .WORD_W     (WORD_W),
        .LINE_WORDS (LINE_WORDS),
        .IDX_W      (CNT_W)
    ) u_line_buffer (
        .clk         (clk),
        .rst         (rst),
        .i_wr_en     (w_buf_wr_en),
        .i_wr_idx    (r_cnt),
        .i_wr_data   (cdb_from_cpu),
        .i_load_en   (w_buf_load),
        .i_load_data (host_rd_data),
        .i_rd_idx    (r_cnt),
        .o_line      (host_wr_data),
        .o_rd_word   (w_rd_word)
    );

    // Every output is a decode of registered state, so async reset clears them at once.
    assign rd_valid     = (r_state == ST_RD_STRM);
    assign cdb_to_cpu   = rd_valid ? w_rd_word : '0;
    assign tx_done      = (rd_valid && w_last) || (r_state == ST_WR_DONE);
    assign host_rd_req  = (r_state == ST_RD_REQ);
    assign host_wr_req  = (r_state == ST_WR_REQ);
    assign host_rd_addr = r_addr & C_ALIGN_MASK;
    assign host_wr_addr = r_addr & C_ALIGN_MASK;

endmodule
`default_nettype wire

// File: tb/tb_cdb_mem_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_cdb_mem_responder
// Brief    : Scoreboard bench for cdb_mem_responder with a host memory model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cdb_mem_responder;

    typedef struct packed {
        logic [31:0] d;
        logic        last;
    } word_t;

    typedef struct packed {
        logic [63:0]  a;
        logic [511:0] d;
    } wr_t;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic [1:0]   op = 2'b00;
    logic [63:0]  io_address = '0;
    logic [31:0]  cdb_from_cpu = '0;
    logic [31:0]  cdb_to_cpu;
    logic         rd_valid;
    logic         tx_done;
    logic         host_rd_req;
    logic [63:0]  host_rd_addr;
    logic         host_rd_valid = 1'b0;
    logic [511:0] host_rd_data = '0;
    logic         host_wr_req;
    logic [63:0]  host_wr_addr;
    logic [511:0] host_wr_data;
    logic         host_wr_ack = 1'b0;

    cdb_mem_responder dut (
        .clk           (clk),
        .rst           (rst),
        .op            (op),
        .io_address    (io_address),
        .cdb_from_cpu  (cdb_from_cpu),
        .cdb_to_cpu    (cdb_to_cpu),
        .rd_valid      (rd_valid),
        .tx_done       (tx_done),
        .host_rd_req   (host_rd_req),
        .host_rd_addr  (host_rd_addr),
        .host_rd_valid (host_rd_valid),
        .host_rd_data  (host_rd_data),
        .host_wr_req   (host_wr_req),
        .host_wr_addr  (host_wr_addr),
        .host_wr_data  (host_wr_data),
        .host_wr_ack   (host_wr_ack)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference memory (what the CPU believes) and host memory (what the DUT wrote).
    logic [511:0] ref_mem  [longint unsigned];
    logic [511:0] host_mem [longint unsigned];

    function automatic logic [511:0] pat(input longint unsigned line);
        logic [511:0] p;
        for (int i = 0; i < 16; i++)
            p[32*i +: 32] = ((32'(line) << 4) + 32'(i)) ^ 32'h5A5A_0000;
        return p;
    endfunction

    function automatic logic [511:0] ref_get(input longint unsigned line);
        return ref_mem.exists(line) ? ref_mem[line] : pat(line);
    endfunction

    function automatic logic [511:0] host_get(input longint unsigned line);
        return host_mem.exists(line) ? host_mem[line] : pat(line);
    endfunction

    // ---------------- host model ----------------
    int           rd_cd = 0, wr_cd = 0, rd_lat = 5, wr_lat = 3;
    logic [511:0] rd_pend = '0;
    bit           rd_real = 0, ack_real = 0, stray_rd = 0, stray_wr = 0;

    initial forever begin
        @(negedge clk);
        if (!rst) begin
            if (host_rd_req) begin
                rd_cd   = rd_lat;
                rd_pend = host_get(host_rd_addr >> 6);
            end
            if (host_wr_req) begin
                wr_cd = wr_lat;
                host_mem[host_wr_addr >> 6] = host_wr_data;
            end
        end
        @(posedge clk);
        #2;
        host_rd_valid = 1'b0;
        host_wr_ack   = 1'b0;
        host_rd_data  = '0;
        rd_real       = 0;
        ack_real      = 0;
        if (rst) begin
            rd_cd = 0;
            wr_cd = 0;
        end
        if (rd_cd > 0) begin
            rd_cd--;
            if (rd_cd == 0) begin
                host_rd_valid = 1'b1;
                host_rd_data  = rd_pend;
                rd_real       = 1;
            end
        end else if (stray_rd) begin
            host_rd_valid = 1'b1;
            host_rd_data  = {16{32'hDEAD_BEEF}};
        end
        stray_rd = 0;
        if (wr_cd > 0) begin
            wr_cd--;
            if (wr_cd == 0) begin
                host_wr_ack = 1'b1;
                ack_real    = 1;
            end
        end else if (stray_wr) begin
            host_wr_ack = 1'b1;
        end
        stray_wr = 0;
    end

    // ---------------- scoreboard monitor ----------------
    word_t       exp_words[$];
    logic [63:0] exp_rd_addr[$];
    wr_t         exp_wr[$];
    bit          wr_done_due = 0, rd_due = 0, mid_burst = 0;
    int          rd_seen = 0, host_req_cnt = 0;

    initial forever begin
        @(negedge clk);
        if (rst) begin
            wr_done_due = 0;
            rd_due      = 0;
            mid_burst   = 0;
        end else begin : mon
            bit    exp_tx;
            word_t w;
            wr_t   e;
            exp_tx = wr_done_due;
            if (rd_due)    chk("rd_latency", 512'(rd_valid), 512'(1));
            if (mid_burst) chk("rd_contiguous", 512'(rd_valid), 512'(1));
            mid_burst = 0;
            if (rd_valid) begin
                rd_seen++;
                if (exp_words.size() == 0) begin
                    chk("rd_valid_unexpected", 512'(rd_valid), 512'(0));
                end else begin
                    w = exp_words.pop_front();
                    chk("rd_data", 512'(cdb_to_cpu), 512'(w.d));
                    exp_tx    = w.last;
                    mid_burst = !w.last;
                end
            end else begin
                chk("cdb_zero_when_idle", 512'(cdb_to_cpu), 512'(0));
            end
            if (tx_done || exp_tx) chk("tx_done", 512'(tx_done), 512'(exp_tx));
            wr_done_due = host_wr_ack && ack_real;
            rd_due      = host_rd_valid && rd_real;
            if (host_rd_req) begin
                host_req_cnt++;
                if (exp_rd_addr.size() == 0) chk("host_rd_req_unexpected", 512'(host_rd_req), 512'(0));
                else chk("host_rd_addr", 512'(host_rd_addr), 512'(exp_rd_addr.pop_front()));
            end
            if (host_wr_req) begin
                host_req_cnt++;
                if (exp_wr.size() == 0) begin
                    chk("host_wr_req_unexpected", 512'(host_wr_req), 512'(0));
                end else begin
                    e = exp_wr.pop_front();
                    chk("host_wr_addr", 512'(host_wr_addr), 512'(e.a));
                    chk("host_wr_data", host_wr_data, e.d);
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic issue_read(input logic [63:0] addr, input int lat, input bit toggle);
        logic [511:0] line;
        word_t        w;
        rd_lat = lat;
        line   = ref_get(addr >> 6);
        exp_rd_addr.push_back({addr[63:6], 6'b0});
        for (int i = 0; i < 16; i++) begin
            w.d    = line[32*i +: 32];
            w.last = (i == 15);
            exp_words.push_back(w);
        end
        @(posedge clk); #1;
        op         = 2'b01;
        io_address = addr;
        @(posedge clk); #1;
        op         = toggle ? 2'b11 : 2'b00;
        io_address = {$urandom, $urandom};
        if (toggle) begin
            @(posedge clk); #1; op = 2'b01;
            @(posedge clk); #1; op = 2'b11;
            @(posedge clk); #1; op = 2'b00;
        end
    endtask

    task automatic wait_done(input string name);
        bit seen = 0;
        for (int k = 0; k < 300 && !seen; k++) begin
            @(negedge clk);
            seen = tx_done;
        end
        #1;
        chk(name, 512'(seen), 512'(1));
        chk({name, "_drained"}, 512'(exp_words.size() + exp_rd_addr.size() + exp_wr.size()), 512'(0));
    endtask

    task automatic do_write(input logic [63:0] addr, input logic [511:0] data,
                            input int lat, input int stray_at);
        wr_t e;
        wr_lat = lat;
        e.a    = {addr[63:6], 6'b0};
        e.d    = data;
        exp_wr.push_back(e);
        @(posedge clk); #1;
        op           = 2'b11;
        io_address   = addr;
        cdb_from_cpu = $urandom;
        for (int i = 0; i < 16; i++) begin
            @(posedge clk); #1;
            op           = 2'($urandom);
            io_address   = {$urandom, $urandom};
            cdb_from_cpu = data[32*i +: 32];
            if (i == stray_at) stray_rd = 1;
        end
        @(posedge clk); #1;
        op           = 2'b00;
        cdb_from_cpu = $urandom;
        ref_mem[addr >> 6] = data;
        wait_done("write_done");
    endtask

    task automatic chk_outputs_zero(input string tag);
        chk({tag, "_cdb_to_cpu"},   512'(cdb_to_cpu),   512'(0));
        chk({tag, "_rd_valid"},     512'(rd_valid),     512'(0));
        chk({tag, "_tx_done"},      512'(tx_done),      512'(0));
        chk({tag, "_host_rd_req"},  512'(host_rd_req),  512'(0));
        chk({tag, "_host_rd_addr"}, 512'(host_rd_addr), 512'(0));
        chk({tag, "_host_wr_req"},  512'(host_wr_req),  512'(0));
        chk({tag, "_host_wr_addr"}, 512'(host_wr_addr), 512'(0));
        chk({tag, "_host_wr_data"}, host_wr_data,       512'(0));
    endtask

    initial begin
        logic [511:0] line_a, line_b, rnd;
        logic [63:0]  lines [5];
        int           base_cnt, start_seen;

        lines[0] = 64'h1000; lines[1] = 64'h1040; lines[2] = 64'h2000;
        lines[3] = 64'h3000; lines[4] = 64'h3FC0;
        for (int i = 0; i < 16; i++) begin
            line_a[32*i +: 32] = 32'hA000_0000 + 32'(i);
            line_b[32*i +: 32] = 32'h0000_00B0 + 32'(i);
        end
        ref_mem[64'h1040 >> 6]  = line_a;
        host_mem[64'h1040 >> 6] = line_a;

        #1 rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk_outputs_zero("reset");
        rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;

        // Directed read and write
        issue_read(64'h1047, 5, 0);
        wait_done("read_directed");
        do_write(64'h400, line_b, 3, -1);

        // Loopback: read a line, write it elsewhere, read it back
        issue_read(64'h1040, 2, 0);
        wait_done("loop_read");
        do_write(64'h2000, ref_get(64'h1040 >> 6), 1, -1);
        issue_read(64'h2000, 1, 0);
        wait_done("loop_readback");

        // Reserved and NOP ops must not reach the host
        base_cnt = host_req_cnt;
        @(posedge clk); #1; op = 2'b10;
        repeat (20) @(posedge clk);
        #1; op = 2'b00;
        repeat (20) @(posedge clk);
        #1;
        chk("op_ignore_no_req", 512'(host_req_cnt), 512'(base_cnt));

        // op toggling during the read wait
        issue_read(64'h1047, 6, 1);
        wait_done("read_op_toggle");

        // Stray ack in IDLE, stray read-valid during write capture
        stray_wr = 1;
        repeat (4) @(posedge clk);
        #1;
        do_write(64'h800, pat(64'h77), 2, 7);
        issue_read(64'h800, 3, 0);
        wait_done("read_after_stray");

        // Reset at the 8th streamed word
        issue_read(64'h1047, 5, 0);
        start_seen = rd_seen;
        for (int k = 0; k < 100 && rd_seen < start_seen + 8; k++) begin
            @(negedge clk); #1;
        end
        chk("reached_8th_word", 512'(rd_seen - start_seen), 512'(8));
        rst = 1'b1;
        #1;
        chk_outputs_zero("midrst");
        exp_words.delete();
        exp_rd_addr.delete();
        exp_wr.delete();
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst      = 1'b0;
        stray_wr = 1;
        @(posedge clk); #1;
        stray_rd = 1;
        repeat (3) @(posedge clk);
        #1;
        issue_read(64'h1047, 5, 0);
        wait_done("read_after_reset");

        // Randomised mix
        for (int t = 0; t < 24; t++) begin
            logic [63:0] a;
            a = lines[$urandom_range(0, 4)] | 64'($urandom_range(0, 63));
            if ($urandom_range(0, 1) == 1) begin
                issue_read(a, $urandom_range(1, 6), 1'($urandom_range(0, 1)));
                wait_done("rand_read");
            end else begin
                for (int i = 0; i < 16; i++) rnd[32*i +: 32] = $urandom;
                do_write(a, rnd, $urandom_range(1, 6), $urandom_range(0, 24));
            end
        end

        repeat (5) @(posedge clk);
        #1;
        chk("scoreboard_empty", 512'(exp_words.size() + exp_rd_addr.size() + exp_wr.size()), 512'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
